// File: rtl/wb_host_bridge.sv
// rtl/wb_host_bridge.sv - single-outstanding command/response to Wishbone initiator bridge
module wb_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hf00df00d
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o,
    output logic [7:0]  timeout_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       ack_hit;
    logic       timeout_hit;

    // Gated by reset so the handshake is closed while reset is held.
    assign cmd_ready_o = wb_rst_ni && (state == IDLE);
    assign busy_o      = wb_rst_ni && (state != IDLE);

    assign accept      = cmd_valid_i && cmd_ready_o;
    assign ack_hit     = (state == BUS) && wbm_ack_i;
    assign timeout_hit = (state == BUS) && !wbm_ack_i && (wait_cnt == WAIT_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUS;
            BUS:     if (ack_hit || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= 4'h0;
            wbm_adr_o     <= 32'h0;
            wbm_dat_o     <= 32'h0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_dat_o     <= 32'h0;
            wait_cnt      <= 8'h0;
            timeout_cnt_o <= 8'h0;
        end else begin
            if (accept) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_we_i ? cmd_dat_i : 32'h0;
                wait_cnt  <= 8'h0;
            end

            // Bus outputs return to zero on exit so we/sel/adr only show during a cycle.
            if (ack_hit || timeout_hit) begin
                wbm_cyc_o   <= 1'b0;
                wbm_stb_o   <= 1'b0;
                wbm_we_o    <= 1'b0;
                wbm_sel_o   <= 4'h0;
                wbm_adr_o   <= 32'h0;
                wbm_dat_o   <= 32'h0;
                rsp_valid_o <= 1'b1;
            end

            if (ack_hit) begin
                rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
                rsp_err_o <= 1'b0;
            end else if (timeout_hit) begin
                rsp_dat_o <= ERR_DATA;
                rsp_err_o <= 1'b1;
                if (timeout_cnt_o != 8'hff) begin
                    timeout_cnt_o <= timeout_cnt_o + 8'd1;
                end
            end else if (state == BUS) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if ((state == RESP) && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_host_bridge.sv
// tb/tb_wb_host_bridge.sv - randomized bench with a cycle-count transaction model of the bridge
module tb_wb_host_bridge;

    localparam int          T    = 16;
    localparam logic [31:0] ERRD = 32'hf00df00d;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr, wbm_dat_out, wbm_dat_in;
    logic        busy;
    logic [7:0]  timeout_cnt;

    wb_host_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .cmd_sel_i    (cmd_sel),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat),
        .rsp_err_o    (rsp_err),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_stb_o    (wbm_stb),
        .wbm_we_o     (wbm_we),
        .wbm_sel_o    (wbm_sel),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat_out),
        .wbm_ack_i    (wbm_ack),
        .wbm_dat_i    (wbm_dat_in),
        .busy_o       (busy),
        .timeout_cnt_o(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          bus_cycles;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          ack_q[$];
    logic [31:0] model_mem[16];
    logic [31:0] slave_mem[16];
    int          checks = 0;
    int          errors = 0;
    int          cyc_num = 0;
    int          late_ack = 0;
    int          last_bus_len = 0;

    always @(posedge clk) cyc_num = cyc_num + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_num);
        end
    endtask

    task automatic fail_now(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc_num);
    endtask

    // The slave at word 0x1C reads back the register at 0x18.
    function automatic logic [3:0] rd_idx(input logic [31:0] adr);
        return (adr[5:2] == 4'd7) ? 4'd6 : adr[5:2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int ack);
        txn_t t;
        t.we         = we;
        t.adr        = adr;
        t.sel        = sel;
        t.dat        = we ? dat : 32'h0;
        t.err        = (ack == 0) || (ack > T);
        t.bus_cycles = t.err ? T : ack;
        if (t.err)     t.rdata = ERRD;
        else if (we)   t.rdata = 32'h0;
        else           t.rdata = model_mem[rd_idx(adr)];
        if (!t.err && we) model_mem[adr[5:2]] = merge(model_mem[adr[5:2]], dat, sel);
        exp_q.push_back(t);
        ack_q.push_back(ack);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 200) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        if (n >= 200) begin
            fail_now("accept");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            at = cyc_num;
        end
    endtask

    task automatic get_rsp(input int dly, output logic [31:0] d, output logic e, output int hs);
        int n;
        n  = 0;
        hs = -1;
        d  = 32'h0;
        e  = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
        end
        if (n >= 100) begin
            fail_now("rsp_valid");
            return;
        end
        d = rsp_dat;
        e = rsp_err;
        repeat (dly + 1) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        hs = cyc_num;
        rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack, input int dly,
                           output logic [31:0] d, output logic e);
        int at, hs;
        send_cmd(we, adr, dat, sel, ack);
        wait_accept(at);
        get_rsp(dly, d, e, hs);
    endtask

    // Wishbone responder: acks on the ack_at-th cycle of cyc/stb, optionally a stray ack later.
    initial begin
        int bus_cnt, since, cur_ack;
        bus_cnt = 0;
        since   = 0;
        cur_ack = 0;
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            wbm_ack    = 1'b0;
            wbm_dat_in = $urandom;
            if (wbm_cyc && wbm_stb) begin
                if (bus_cnt == 0) cur_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
                bus_cnt++;
                since = 0;
                if (bus_cnt == cur_ack) begin
                    wbm_ack = 1'b1;
                    if (wbm_we) slave_mem[wbm_adr[5:2]] = merge(slave_mem[wbm_adr[5:2]], wbm_dat_out, wbm_sel);
                    else        wbm_dat_in = slave_mem[rd_idx(wbm_adr)];
                end
            end else begin
                if (bus_cnt != 0) last_bus_len = bus_cnt;
                bus_cnt = 0;
                since++;
                if (late_ack != 0 && since == late_ack) wbm_ack = 1'b1;
            end
        end
    end

    // Compare process: model tracks BUS cycles left and response pending, checks every cycle.
    initial begin
        int         bus_left;
        bit         m_rsp, rst_edge;
        logic [7:0] m_to;
        bus_left = 0;
        m_rsp    = 0;
        rst_edge = 0;
        m_to     = 8'h0;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                chk("rst_cyc", 32'(wbm_cyc), 32'h0);
                chk("rst_stb", 32'(wbm_stb), 32'h0);
                chk("rst_we", 32'(wbm_we), 32'h0);
                chk("rst_sel", 32'(wbm_sel), 32'h0);
                chk("rst_adr", wbm_adr, 32'h0);
                chk("rst_wdat", wbm_dat_out, 32'h0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                chk("rst_rsp_err", 32'(rsp_err), 32'h0);
                chk("rst_rsp_dat", rsp_dat, 32'h0);
                chk("rst_timeout_cnt", 32'(timeout_cnt), 32'h0);
            end
            if (!rstn) begin
                chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                rst_edge = 1;
                bus_left = 0;
                m_rsp    = 0;
                m_to     = 8'h0;
            end else begin
                rst_edge = 0;
                chk("cyc", 32'(wbm_cyc), 32'(bus_left > 0));
                chk("stb", 32'(wbm_stb), 32'(bus_left > 0));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
                chk("busy", 32'(busy), 32'((bus_left > 0) || m_rsp));
                chk("cmd_ready", 32'(cmd_ready), 32'(!((bus_left > 0) || m_rsp)));
                chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
                if (bus_left > 0) begin
                    chk("wbm_adr", wbm_adr, cur.adr);
                    chk("wbm_we", 32'(wbm_we), 32'(cur.we));
                    chk("wbm_sel", 32'(wbm_sel), 32'(cur.sel));
                    chk("wbm_dat", wbm_dat_out, cur.dat);
                end else begin
                    chk("wbm_we_idle", 32'(wbm_we), 32'h0);
                end
                if (m_rsp) begin
                    chk("rsp_dat", rsp_dat, cur.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                end
                if (bus_left > 0) begin
                    bus_left--;
                    if (bus_left == 0) begin
                        m_rsp = 1;
                        if (cur.err && m_to != 8'hff) m_to = m_to + 8'd1;
                    end
                end else if (m_rsp) begin
                    if (rsp_ready) m_rsp = 0;
                end else if (cmd_valid) begin
                    if (exp_q.size() == 0) begin
                        fail_now("model_queue");
                    end else begin
                        cur      = exp_q.pop_front();
                        bus_left = cur.bus_cycles;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          at_a, at_b, hs, dummy;

        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            slave_mem[i] = model_mem[i];
        end
        model_mem[1] = 32'h4669626f;
        slave_mem[1] = 32'h4669626f;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Read with ack on the second bus cycle.
        run_txn(1'b0, 32'h30000004, 32'h0, 4'hf, 2, 0, d, e);
        chk("rd_data", d, 32'h4669626f);
        chk("rd_err", 32'(e), 32'h0);
        chk("rd_bus_len", 32'(last_bus_len), 32'd2);

        // Write then read back through the 0x1C readback register.
        run_txn(1'b1, 32'h30000018, 32'h12345678, 4'hf, 2, 1, d, e);
        chk("wr_rsp_dat", d, 32'h0);
        chk("wr_err", 32'(e), 32'h0);
        run_txn(1'b0, 32'h3000001C, 32'h0, 4'hf, 2, 0, d, e);
        chk("rdback_data", d, 32'h12345678);

        // Timeout with a stray ack three cycles after cyc drops.
        late_ack = 3;
        run_txn(1'b0, 32'h30000008, 32'h0, 4'hf, 0, 5, d, e);
        late_ack = 0;
        chk("to_bus_len", 32'(last_bus_len), 32'd16);
        chk("to_data", d, 32'hf00df00d);
        chk("to_err", 32'(e), 32'h1);
        chk("to_count", 32'(timeout_cnt), 32'd1);

        // Response back-pressure while the next command is already valid.
        send_cmd(1'b0, 32'h30000008, 32'h0, 4'hf, 3);
        wait_accept(at_a);
        send_cmd(1'b0, 32'h30000004, 32'h0, 4'hf, 1);
        get_rsp(4, d, e, hs);
        wait_accept(at_b);
        chk("hold_accept_gap", 32'(at_b - hs), 32'd1);
        get_rsp(0, d, e, dummy);
        chk("hold_second_data", d, 32'h4669626f);

        // Ack on the last allowed bus cycle beats the timeout.
        run_txn(1'b0, 32'h30000004, 32'h0, 4'hf, 16, 0, d, e);
        chk("edge_ack_err", 32'(e), 32'h0);
        chk("edge_ack_data", d, 32'h4669626f);
        chk("edge_ack_len", 32'(last_bus_len), 32'd16);
        chk("edge_ack_count", 32'(timeout_cnt), 32'd1);

        // One-cycle reset in the middle of a bus cycle.
        send_cmd(1'b0, 32'h30000004, 32'h0, 4'hf, 0);
        wait_accept(at_a);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_txn(1'b0, 32'h30000004, 32'h0, 4'hf, 1, 0, d, e);
        chk("post_rst_data", d, 32'h4669626f);
        chk("post_rst_err", 32'(e), 32'h0);
        chk("post_rst_count", 32'(timeout_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic        we;
            logic [31:0] adr;
            we  = 1'($urandom_range(0, 1));
            adr = 32'h30000000 | (32'($urandom_range(0, 15)) << 2);
            run_txn(we, adr, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 20),
                    $urandom_range(0, 3), d, e);
        end

        // Drive the timeout counter into saturation.
        for (int i = 0; i < 260; i++) begin
            run_txn(1'b0, 32'h30000000, 32'h0, 4'hf, 0, 0, d, e);
        end
        chk("to_saturated", 32'(timeout_cnt), 32'd255);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of BUS-state cycles without ack before abort (legal range 2..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hf00df00d, meaning the read data returned on timeout.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_ni, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port cmd_valid_i, input, 1, command request.
REQ-006 SHALL have port cmd_ready_o, output, 1, command accepted when high together with cmd_valid_i.
REQ-007 SHALL have ports cmd_we_i (input, 1, write), cmd_adr_i (input, 32, address), cmd_dat_i (input, 32, write data) and cmd_sel_i (input, 4, byte lanes).
REQ-008 SHALL have ports rsp_valid_o (output, 1), rsp_ready_i (input, 1), rsp_dat_o (output, 32, read data) and rsp_err_o (output, 1, timeout flag).
REQ-009 SHALL have Wishbone initiator ports wbm_cyc_o, wbm_stb_o and wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o and wbm_dat_o (output, 32 each), wbm_ack_i (input, 1) and wbm_dat_i (input, 32).
REQ-010 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port timeout_cnt_o, output, 8, the saturating count of timed-out transactions.

Function
REQ-012 SHALL implement three states: IDLE, BUS and RESP, with one outstanding transaction maximum.
REQ-013 SHALL drive cmd_ready_o combinationally high only in IDLE.
REQ-014 In IDLE, on cmd_valid_i and cmd_ready_o at edge N, SHALL latch we/adr/dat/sel, enter BUS, and drive wbm_cyc_o = wbm_stb_o = 1 from cycle N+1.
REQ-015 All wbm_* outputs SHALL be registered and SHALL stay stable for the whole of BUS.
REQ-016 wbm_dat_o SHALL carry the latched write data for writes and 0 for reads.
REQ-017 In BUS, a wait counter SHALL clear on entry and increment each cycle that wbm_ack_i is low.
REQ-018 In BUS, when wbm_ack_i is sampled high, SHALL on that same edge deassert cyc/stb, capture rsp_dat_o (wbm_dat_i for reads, 0 for writes), clear rsp_err_o and enter RESP.
REQ-019 In BUS, when the counter reaches TIMEOUT_CYCLES-1 with ack low, SHALL deassert cyc/stb, set rsp_dat_o = ERR_DATA and rsp_err_o = 1, increment timeout_cnt_o (saturating at 255) and enter RESP.
REQ-020 If ack is high in the same cycle the timeout would fire, ack SHALL win and no error is flagged.
REQ-021 In RESP, SHALL hold rsp_valid_o = 1 and keep rsp_dat_o and rsp_err_o stable until rsp_ready_i is high.
REQ-022 On that rsp_ready_i edge, SHALL drop rsp_valid_o and return to IDLE; a new command is accepted no earlier than the following cycle.
REQ-023 SHALL ignore wbm_ack_i in IDLE and RESP, including late acks after a timeout.
REQ-024 Minimum latency, with ack on the first BUS cycle, SHALL be: accept at N, cyc/stb high during N+1, rsp_valid_o high from N+2.

Reset
REQ-025 While wb_rst_ni is low at an edge, SHALL enter IDLE and clear wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_err_o, rsp_dat_o, the wait counter and timeout_cnt_o.
REQ-026 Reset asserted mid-BUS or mid-RESP SHALL abort the transaction with no response and drop cyc/stb on that edge.
REQ-027 While in reset, cmd_ready_o and busy_o SHALL be 0.

Verification
REQ-028 Read adr 0x30000004, sel 4'hf, responder acks one cycle after stb with 0x4669626f -> rsp_dat_o = 0x4669626f, rsp_err_o = 0, cyc/stb high exactly 2 cycles.
REQ-029 Write 0x12345678 to 0x30000018, then read 0x3000001C -> write response has rsp_dat_o = 0, read returns 0x12345678, wbm_we_o = 1 only during the write.
REQ-030 Read with wbm_ack_i held low -> cyc/stb drop after exactly 16 BUS cycles, rsp_dat_o = 0xf00df00d, rsp_err_o = 1, timeout_cnt_o = 1; an ack 3 cycles later is ignored.
REQ-031 rsp_ready_i low for 5 cycles after response, cmd_valid_i held high -> rsp_valid_o and rsp_dat_o stable, cmd_ready_o low throughout, next command accepted on the cycle after the handshake.
REQ-032 wb_rst_ni low for 1 cycle during BUS -> cyc/stb 0 next cycle, no rsp_valid_o, next command completes normally.
REQ-033 Ack arriving on the 16th BUS cycle -> rsp_err_o = 0, timeout_cnt_o unchanged.
